// File: rtl/eth_tx_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : eth_tx_arb_pkg                                                    |
// | Purpose: Shared types and constants for the Ethernet TX frame arbiter:     |
// |          scheduler state encoding, statistics counter width, default       |
// |          frame-length and inter-frame holdoff values, counter sizing.      |
// | Ports  : none (package)                                                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package eth_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam int CNT_W                   = 16;
   localparam int DEFAULT_MAX_FRAME_BYTES = 1514;
   localparam int DEFAULT_GAP_CYCLES      = 12;

   // Bits needed to hold the values 0..max_val (never less than one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arbiter                                                        |
// | Purpose: Combinational round-robin pick. Searches req_i starting at the    |
// |          position just above ptr_i, wrapping, and returns the first set    |
// |          request.                                                          |
// | Ports  : req_i  [N]      request vector                                    |
// |          ptr_i  [IDX_W]  index of the most recent winner                   |
// |          idx_o  [IDX_W]  index of the chosen request                       |
// |          any_o           at least one request is set                       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic [IDX_W-1:0]     ptr_i,
   output logic [IDX_W-1:0]     idx_o,
   output logic                 any_o
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;
   logic             found;

   // Walk the ring from ptr+1 to ptr+NUM_PORTS (ptr itself last), so the
   // previous winner has the lowest priority.
   always_comb begin
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand     = (int'(ptr_i) + i) % NUM_PORTS;
         cand_idx = IDX_W'(cand);
         if (!found && req_i[cand_idx]) begin
            found = 1'b1;
            idx_o = cand_idx;
         end
      end
   end

   assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : eth_tx_arbiter                                                    |
// | Purpose: Frame-granular round-robin scheduler sharing one byte-wide MAC    |
// |          TX AXI-Stream among NUM_PORTS sources. Holds the grant for a      |
// |          whole frame, truncates at MAX_FRAME_BYTES (draining the rest of   |
// |          the source frame) and inserts a GAP_CYCLES holdoff between        |
// |          frames. mac_tx_busy blocks new arbitration.                       |
// | Ports  : clk, rst (async, active-high)                                     |
// |          s_axis_tdata/tvalid/tlast in, s_axis_tready out (per source)      |
// |          m_axis_tdata/tvalid/tlast out, m_axis_tready in (toward MAC)      |
// |          mac_tx_busy in                                                    |
// |          grant_valid, grant_idx, frames_sent, frames_truncated out         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module eth_tx_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int NUM_PORTS       = 4,
   parameter int MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES,
   parameter int GAP_CYCLES      = DEFAULT_GAP_CYCLES
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [8*NUM_PORTS-1:0]         s_axis_tdata,
   input  logic [NUM_PORTS-1:0]           s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]           s_axis_tlast,
   output logic [NUM_PORTS-1:0]           s_axis_tready,
   output logic [7:0]                     m_axis_tdata,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready,
   input  logic                           mac_tx_busy,
   output logic                           grant_valid,
   output logic [$clog2(NUM_PORTS)-1:0]   grant_idx,
   output logic [CNT_W-1:0]               frames_sent,
   output logic [CNT_W-1:0]               frames_truncated
);

   localparam int IDX_W    = $clog2(NUM_PORTS);
   localparam int BYTE_W   = cnt_width(MAX_FRAME_BYTES);
   localparam int GAP_W    = cnt_width(GAP_CYCLES);
   localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]   frames_sent_q, frames_sent_d;
   logic [CNT_W-1:0]   frames_trunc_q, frames_trunc_d;

   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_any;
   logic [NUM_PORTS-1:0] sel_onehot;
   logic [7:0]           sel_data;
   logic                 sel_valid;
   logic                 sel_last;
   logic                 at_max;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr (
      .req_i (s_axis_tvalid),
      .ptr_i (ptr_q),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   // Source-side view of the granted port.
   always_comb begin
      sel_onehot = '0;
      sel_data   = '0;
      sel_valid  = 1'b0;
      sel_last   = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant_idx_q == IDX_W'(p)) begin
            sel_onehot[p] = 1'b1;
            sel_data      = s_axis_tdata[p*8 +: 8];
            sel_valid     = s_axis_tvalid[p];
            sel_last      = s_axis_tlast[p];
         end
      end
   end

   // The beat that would make the frame MAX_FRAME_BYTES long.
   assign at_max = (byte_cnt_q == BYTE_W'(MAX_FRAME_BYTES - 1));

   always_comb begin
      state_d        = state_q;
      grant_idx_d    = grant_idx_q;
      ptr_d          = ptr_q;
      byte_cnt_d     = byte_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      frames_sent_d  = frames_sent_q;
      frames_trunc_d = frames_trunc_q;
      m_axis_tdata   = '0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      s_axis_tready  = '0;
      grant_valid    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_any && !mac_tx_busy) begin
               grant_idx_d = arb_idx;
               ptr_d       = arb_idx;
               byte_cnt_d  = '0;
               state_d     = ST_XFER;
            end
         end

         ST_XFER: begin
            grant_valid   = 1'b1;
            m_axis_tdata  = sel_data;
            m_axis_tvalid = sel_valid;
            m_axis_tlast  = sel_last | at_max;
            s_axis_tready = sel_onehot & {NUM_PORTS{m_axis_tready}};
            if (sel_valid && m_axis_tready) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               // A source tlast on the limit beat is a normal end of frame.
               if (sel_last) begin
                  frames_sent_d = frames_sent_q + 1'b1;
                  gap_cnt_d     = '0;
                  state_d       = ST_GAP;
               end else if (at_max) begin
                  frames_sent_d  = frames_sent_q + 1'b1;
                  frames_trunc_d = frames_trunc_q + 1'b1;
                  state_d        = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            // Swallow the overlong tail so the source can move on.
            grant_valid   = 1'b1;
            s_axis_tready = sel_onehot;
            if (sel_valid && sel_last) begin
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end
         end

         ST_GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         grant_idx_q    <= '0;
         ptr_q          <= IDX_W'(NUM_PORTS - 1);
         byte_cnt_q     <= '0;
         gap_cnt_q      <= '0;
         frames_sent_q  <= '0;
         frames_trunc_q <= '0;
      end else begin
         state_q        <= state_d;
         grant_idx_q    <= grant_idx_d;
         ptr_q          <= ptr_d;
         byte_cnt_q     <= byte_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         frames_sent_q  <= frames_sent_d;
         frames_trunc_q <= frames_trunc_d;
      end
   end

   assign grant_idx        = grant_idx_q;
   assign frames_sent      = frames_sent_q;
   assign frames_truncated = frames_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_eth_tx_arbiter                                                 |
// | Purpose: Directed self-checking bench for eth_tx_arbiter. A per-port       |
// |          source model supplies frames with known byte patterns; a monitor  |
// |          checks every frame reaching the MAC against the expected grant    |
// |          order, byte pattern, tlast position and inter-frame gap.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_eth_tx_arbiter;

   localparam int N    = 4;
   localparam int MAXB = 1514;
   localparam int GAP  = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic [8*N-1:0]   s_tdata;
   logic [N-1:0]     s_tvalid, s_tlast, s_tready;
   logic [7:0]       m_tdata;
   logic             m_tvalid, m_tlast, m_tready;
   logic             busy;
   logic             gv;
   logic [1:0]       gidx;
   logic [15:0]      fsent, ftrunc;

   always #5 clk = ~clk;

   eth_tx_arbiter #(
      .NUM_PORTS       (N),
      .MAX_FRAME_BYTES (MAXB),
      .GAP_CYCLES      (GAP)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .s_axis_tdata     (s_tdata),
      .s_axis_tvalid    (s_tvalid),
      .s_axis_tlast     (s_tlast),
      .s_axis_tready    (s_tready),
      .m_axis_tdata     (m_tdata),
      .m_axis_tvalid    (m_tvalid),
      .m_axis_tlast     (m_tlast),
      .m_axis_tready    (m_tready),
      .mac_tx_busy      (busy),
      .grant_valid      (gv),
      .grant_idx        (gidx),
      .frames_sent      (fsent),
      .frames_truncated (ftrunc)
   );

   int checks = 0;
   int errors = 0;

   // source model
   int src_left  [N];
   int src_beat  [N];
   int src_frame [N];
   int flen      [N];
   bit stall_en;

   // monitor
   int   exp_order[$];
   int   ord_i, mon_beat, mon_bad, mon_frames, last_end, drained, cyc;
   int   mon_frame [N];
   logic smp_gv;
   logic [1:0] smp_gidx;

   function automatic logic [7:0] mkdata(input int p, input int f, input int b);
      int v;
      v = p*61 + f*17 + b*3 + b/256;
      return v[7:0];
   endfunction

   task automatic drive_src();
      for (int p = 0; p < N; p++) begin
         s_tvalid[p]         = (src_left[p] > 0);
         s_tdata[p*8 +: 8]   = mkdata(p, src_frame[p], src_beat[p]);
         s_tlast[p]          = (src_left[p] > 0) && (src_beat[p] == flen[p] - 1);
      end
      m_tready = stall_en ? ((cyc % 3) != 0) : 1'b1;
   endtask

   task automatic clear_models();
      for (int p = 0; p < N; p++) begin
         src_left[p] = 0; src_beat[p] = 0; src_frame[p] = 0; flen[p] = 8;
         mon_frame[p] = 0;
      end
      exp_order.delete();
      ord_i = 0; mon_beat = 0; mon_bad = 0; mon_frames = 0; last_end = 0; drained = 0;
      stall_en = 1'b0;
      busy = 1'b0;
      drive_src();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_models();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One clock: sample at the falling edge, update drives just after the rising edge.
   task automatic step();
      logic [N-1:0] sf;
      int           p, exp_beats;
      logic [7:0]   ed;
      logic         el;
      @(negedge clk);
      cyc++;
      smp_gv   = gv;
      smp_gidx = gidx;
      sf = s_tvalid & s_tready;
      checks++;
      if ($countones(s_tready) > 1) begin
         errors++;
         $display("FAIL ready_onehot: s_axis_tready=%b, required at most one bit set", s_tready);
      end
      if (!m_tvalid && (sf != '0)) drained++;
      if (m_tvalid && m_tready) begin
         if (ord_i >= exp_order.size()) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: data=%h with no frame expected", m_tdata);
         end else begin
            p = exp_order[ord_i];
            if (mon_beat == 0) begin
               checks++;
               if (gidx !== 2'(p)) begin
                  errors++;
                  $display("FAIL grant_order: grant_idx=%0d, required %0d (frame %0d)", gidx, p, ord_i);
               end
               if (mon_frames > 0) begin
                  checks++;
                  if (cyc - last_end - 1 < GAP) begin
                     errors++;
                     $display("FAIL frame_gap: idle cycles=%0d, required >= %0d", cyc - last_end - 1, GAP);
                  end
               end
            end
            ed = mkdata(p, mon_frame[p], mon_beat);
            el = (mon_beat == flen[p] - 1) || (mon_beat == MAXB - 1);
            if (m_tdata !== ed || m_tlast !== el) mon_bad++;
            mon_beat++;
            if (m_tlast) begin
               exp_beats = (flen[p] < MAXB) ? flen[p] : MAXB;
               checks++;
               if (mon_beat !== exp_beats) begin
                  errors++;
                  $display("FAIL frame_len: port %0d beats=%0d, required %0d", p, mon_beat, exp_beats);
               end
               checks++;
               if (mon_bad !== 0) begin
                  errors++;
                  $display("FAIL frame_data: port %0d bad beats=%0d, required 0", p, mon_bad);
               end
               mon_frame[p]++;
               ord_i++;
               mon_frames++;
               last_end = cyc;
               mon_beat = 0;
               mon_bad  = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int q = 0; q < N; q++) begin
         if (sf[q]) begin
            if (src_beat[q] == flen[q] - 1) begin
               src_beat[q] = 0;
               src_frame[q]++;
               src_left[q]--;
            end else begin
               src_beat[q]++;
            end
         end
      end
      drive_src();
   endtask

   function automatic bit srcs_done();
      for (int p = 0; p < N; p++) if (src_left[p] != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_until(input int frames, input int budget);
      int n = 0;
      while (!(mon_frames >= frames && srcs_done()) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL timeout: frames=%0d, required %0d within %0d cycles", mon_frames, frames, budget);
      end
      repeat (GAP + 3) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_models();
      src_left[0] = 1;
      drive_src();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({m_tvalid, m_tlast, gv} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: tvalid/tlast/grant=%b, required 000", {m_tvalid, m_tlast, gv});
      end
      checks++;
      if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_data: m_axis_tdata=%h, required 00", m_tdata); end
      checks++;
      if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_ready: s_axis_tready=%b, required 0000", s_tready); end
      checks++;
      if (gidx !== 2'd0) begin errors++; $display("FAIL reset_gidx: grant_idx=%0d, required 0", gidx); end
      checks++;
      if (fsent !== 16'd0 || ftrunc !== 16'd0) begin
         errors++; $display("FAIL reset_counters: sent=%0d trunc=%0d, required 0 0", fsent, ftrunc);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      clear_models();
   endtask

   task automatic test_single_frame();
      do_reset();
      flen[0] = 64; src_left[0] = 1;
      exp_order = {0};
      drive_src();
      run_until(1, 300);
      checks++;
      if (fsent !== 16'd1) begin errors++; $display("FAIL single_sent: frames_sent=%0d, required 1", fsent); end
      checks++;
      if (ftrunc !== 16'd0) begin errors++; $display("FAIL single_trunc: frames_truncated=%0d, required 0", ftrunc); end
      checks++;
      if (gidx !== 2'd0 || gv !== 1'b0) begin
         errors++; $display("FAIL single_grant: grant_idx=%0d grant_valid=%b, required 0 0", gidx, gv);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      flen[0] = 6; flen[1] = 5; flen[2] = 7;
      src_left[0] = 3; src_left[1] = 3; src_left[2] = 3;
      stall_en = 1'b1;
      exp_order = {0, 1, 2, 0, 1, 2, 0, 1, 2};
      drive_src();
      run_until(9, 2000);
      checks++;
      if (fsent !== 16'd9) begin errors++; $display("FAIL rr_sent: frames_sent=%0d, required 9", fsent); end
      checks++;
      if (mon_frames !== 9) begin errors++; $display("FAIL rr_frames: frames seen=%0d, required 9", mon_frames); end
   endtask

   task automatic test_truncate();
      do_reset();
      flen[1] = 1600; src_left[1] = 1;
      exp_order = {1};
      drive_src();
      run_until(1, 4000);
      checks++;
      if (drained !== 86) begin errors++; $display("FAIL trunc_drain: drained beats=%0d, required 86", drained); end
      checks++;
      if (ftrunc !== 16'd1) begin errors++; $display("FAIL trunc_count: frames_truncated=%0d, required 1", ftrunc); end
      checks++;
      if (fsent !== 16'd1) begin errors++; $display("FAIL trunc_sent: frames_sent=%0d, required 1", fsent); end
   endtask

   task automatic test_exact_max();
      do_reset();
      flen[3] = MAXB; src_left[3] = 1;
      exp_order = {3};
      drive_src();
      run_until(1, 4000);
      checks++;
      if (drained !== 0) begin errors++; $display("FAIL exact_drain: drained beats=%0d, required 0", drained); end
      checks++;
      if (ftrunc !== 16'd0) begin errors++; $display("FAIL exact_trunc: frames_truncated=%0d, required 0", ftrunc); end
      checks++;
      if (fsent !== 16'd1) begin errors++; $display("FAIL exact_sent: frames_sent=%0d, required 1", fsent); end
   endtask

   task automatic test_busy();
      logic saw_gv;
      logic saw_rdy;
      do_reset();
      busy = 1'b1;
      flen[2] = 8; src_left[2] = 1;
      exp_order = {2};
      drive_src();
      saw_gv  = 1'b0;
      saw_rdy = 1'b0;
      repeat (10) begin
         step();
         saw_gv  = saw_gv | smp_gv;
         saw_rdy = saw_rdy | (|s_tready);
      end
      checks++;
      if (saw_gv !== 1'b0 || saw_rdy !== 1'b0) begin
         errors++; $display("FAIL busy_hold: grant seen=%b ready seen=%b, required 0 0", saw_gv, saw_rdy);
      end
      busy = 1'b0;
      step();
      checks++;
      if (smp_gv !== 1'b0) begin errors++; $display("FAIL busy_early: grant_valid=%b, required 0", smp_gv); end
      step();
      checks++;
      if (smp_gv !== 1'b1 || smp_gidx !== 2'd2) begin
         errors++; $display("FAIL busy_grant: grant_valid=%b grant_idx=%0d, required 1 2", smp_gv, smp_gidx);
      end
      run_until(1, 200);
      checks++;
      if (fsent !== 16'd1) begin errors++; $display("FAIL busy_sent: frames_sent=%0d, required 1", fsent); end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      flen[1] = 4; src_left[1] = 1;
      exp_order = {1, 0};
      drive_src();
      run_until(1, 200);
      flen[0] = 64; src_left[0] = 1;
      drive_src();
      n = 0;
      while (mon_beat < 20 && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (mon_beat !== 20 || fsent !== 16'd1) begin
         errors++; $display("FAIL mid_setup: beats=%0d sent=%0d, required 20 1", mon_beat, fsent);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({m_tvalid, m_tlast, gv} !== 3'b000 || s_tready !== 4'b0000) begin
         errors++;
         $display("FAIL mid_outputs: tvalid/tlast/grant=%b ready=%b, required 000 0000", {m_tvalid, m_tlast, gv}, s_tready);
      end
      checks++;
      if (fsent !== 16'd0 || ftrunc !== 16'd0) begin
         errors++; $display("FAIL mid_counters: sent=%0d trunc=%0d, required 0 0", fsent, ftrunc);
      end
      clear_models();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      flen[0] = 64; src_left[0] = 1;
      exp_order = {0};
      drive_src();
      run_until(1, 300);
      checks++;
      if (fsent !== 16'd1 || ftrunc !== 16'd0) begin
         errors++; $display("FAIL mid_after: sent=%0d trunc=%0d, required 1 0", fsent, ftrunc);
      end
   endtask

   initial begin
      cyc = 0;
      test_reset();
      test_single_frame();
      test_round_robin();
      test_truncate();
      test_exact_max();
      test_busy();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
